// File: rtl/squash_arb_filter.sv
// squash_arb_filter: picks the oldest valid squash, registers it, and filters younger repeats for a window
module squash_arb_filter #(
  parameter int p_num_arb       = 2,
  parameter int p_seq_num_bits  = 5,
  parameter int p_filter_cycles = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [p_num_arb-1:0]                arb_val,
  input  logic [p_num_arb*p_seq_num_bits-1:0] arb_seq_num,
  input  logic [p_num_arb*32-1:0]             arb_target,
  input  logic                                commit_val,
  input  logic [p_seq_num_bits-1:0]           commit_seq_num,
  output logic                                gnt_val,
  output logic [p_seq_num_bits-1:0]           gnt_seq_num,
  output logic [31:0]                         gnt_target
);
  localparam int W  = p_seq_num_bits;
  localparam int CW = p_filter_cycles > 0 ? $clog2(p_filter_cycles + 1) : 1;
  logic [W-1:0]  head, filt_seq, filt_age, cand_seq, cand_age;
  logic [31:0]   cand_tgt;
  logic [CW-1:0] filt_cnt;
  logic          cand_val, accept;
  // Strict less-than keeps the lowest index on equal ages
  always_comb begin
    cand_val = 1'b0;
    cand_seq = '0;
    cand_tgt = '0;
    cand_age = '0;
    for (int i = 0; i < p_num_arb; i++) begin
      logic [W-1:0] a;
      a = arb_seq_num[i*W +: W] - head;
      if (arb_val[i] && (!cand_val || a < cand_age)) begin
        cand_val = 1'b1;
        cand_seq = arb_seq_num[i*W +: W];
        cand_tgt = arb_target[i*32 +: 32];
        cand_age = a;
      end
    end
  end
  assign filt_age = filt_seq - head;
  assign accept   = cand_val && (filt_cnt == '0 || cand_age < filt_age);
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_val     <= 1'b0;
      gnt_seq_num <= '0;
      gnt_target  <= '0;
      head        <= '0;
      filt_seq    <= '0;
      filt_cnt    <= '0;
    end else begin
      gnt_val <= accept;
      if (commit_val) head <= commit_seq_num + 1'b1;
      if (accept) begin
        gnt_seq_num <= cand_seq;
        gnt_target  <= cand_tgt;
        filt_seq    <= cand_seq;
        filt_cnt    <= CW'(p_filter_cycles);
      end else if (filt_cnt != '0) begin
        filt_cnt <= filt_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_squash_arb_filter.sv
// tb_squash_arb_filter: directed checks of ordering, ties, filter window, wrap and reset
module tb_squash_arb_filter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  arb_val;
  logic [9:0]  arb_seq_num;
  logic [63:0] arb_target;
  logic        commit_val;
  logic [4:0]  commit_seq_num;
  logic        gnt_val;
  logic [4:0]  gnt_seq_num;
  logic [31:0] gnt_target;
  int checks = 0;
  int errors = 0;

  squash_arb_filter #(.p_num_arb(2), .p_seq_num_bits(5), .p_filter_cycles(3)) dut (
    .clk(clk), .rst(rst), .arb_val(arb_val), .arb_seq_num(arb_seq_num),
    .arb_target(arb_target), .commit_val(commit_val), .commit_seq_num(commit_seq_num),
    .gnt_val(gnt_val), .gnt_seq_num(gnt_seq_num), .gnt_target(gnt_target)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic src(input int i, input logic v, input logic [4:0] s, input logic [31:0] t);
    arb_val[i]           = v;
    arb_seq_num[i*5 +: 5] = s;
    arb_target[i*32 +: 32] = t;
  endtask

  task automatic gnt(input string tag, input logic v, input logic [4:0] s, input logic [31:0] t);
    check({tag, "_val"}, 32'(gnt_val), 32'(v));
    check({tag, "_seq"}, 32'(gnt_seq_num), 32'(s));
    check({tag, "_tgt"}, gnt_target, t);
  endtask

  initial begin
    rst = 1'b1; arb_val = '0; arb_seq_num = '0; arb_target = '0;
    commit_val = 1'b0; commit_seq_num = '0;
    tick(); tick();
    gnt("reset", 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    // T1
    src(1, 1'b1, 5'd4, 32'h100);
    tick();
    gnt("t1_grant", 1'b1, 5'd4, 32'h100);
    src(1, 1'b0, 5'd0, 32'h0);
    tick();
    gnt("t1_hold", 1'b0, 5'd4, 32'h100);
    tick(); tick(); tick();
    // T2
    src(0, 1'b1, 5'd7, 32'h700);
    src(1, 1'b1, 5'd3, 32'h300);
    tick();
    gnt("t2_oldest", 1'b1, 5'd3, 32'h300);
    arb_val = '0;
    tick(); tick(); tick();
    src(0, 1'b1, 5'd5, 32'hA00);
    src(1, 1'b1, 5'd5, 32'hB00);
    tick();
    gnt("t2_tie", 1'b1, 5'd5, 32'hA00);
    arb_val = '0;
    tick(); tick(); tick();
    // T3
    src(0, 1'b1, 5'd3, 32'h333);
    tick();
    gnt("t3_grant", 1'b1, 5'd3, 32'h333);
    src(0, 1'b1, 5'd6, 32'h666);
    tick();
    check("t3_drop_young", 32'(gnt_val), 32'd0);
    src(0, 1'b1, 5'd3, 32'h333);
    tick();
    check("t3_drop_equal", 32'(gnt_val), 32'd0);
    src(0, 1'b1, 5'd6, 32'h666);
    tick();
    check("t3_drop_last", 32'(gnt_val), 32'd0);
    tick();
    gnt("t3_expired", 1'b1, 5'd6, 32'h666);
    // T4
    src(0, 1'b1, 5'd2, 32'h222);
    tick();
    gnt("t4_override", 1'b1, 5'd2, 32'h222);
    src(0, 1'b1, 5'd4, 32'h444);
    tick();
    gnt("t4_rearm", 1'b0, 5'd2, 32'h222);
    arb_val = '0;
    tick(); tick(); tick();
    // T5
    commit_val = 1'b1; commit_seq_num = 5'd29;
    tick();
    commit_val = 1'b0;
    src(0, 1'b1, 5'd1, 32'h111);
    src(1, 1'b1, 5'd31, 32'h131);
    tick();
    gnt("t5_wrap", 1'b1, 5'd31, 32'h131);
    // T6
    arb_val = '0;
    src(0, 1'b1, 5'd5, 32'h555);
    rst = 1'b1;
    tick();
    gnt("t6_reset", 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    src(0, 1'b1, 5'd4, 32'h444);
    tick();
    gnt("t6_after", 1'b1, 5'd4, 32'h444);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
